// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants and the ALU operation encoding used by decode and the ALU.
package rv32_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU_SUBI exists only to keep the encoding dense; decode never produces it.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_ADDI  = 4'd7,
        ALU_SUBI  = 4'd8,
        ALU_ANDI  = 4'd9,
        ALU_ORI   = 4'd10,
        ALU_XORI  = 4'd11,
        ALU_SLTI  = 4'd12,
        ALU_SLTIU = 4'd13,
        ALU_LUI   = 4'd14,
        ALU_AUIPC = 4'd15
    } rv32_alu_op_e;

endpackage

// File: rtl/rv32_dec_comb.sv
// Combinational instruction table: maps a 32-bit word to ALU op, legality,
// register-use flags and the register address fields.
module rv32_dec_comb
    import rv32_pkg::*;
(
    input  logic [31:0]  instr,
    output rv32_alu_op_e opsel,
    output logic         legal,
    output logic         uses_rs1,
    output logic         uses_rs2,
    output logic         writes_rd,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic [4:0]   rd
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    always_comb begin
        opsel    = ALU_ADD;
        legal    = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  begin opsel = ALU_ADD;  legal = 1'b1; end
                        F3_AND:  begin opsel = ALU_AND;  legal = 1'b1; end
                        F3_OR:   begin opsel = ALU_OR;   legal = 1'b1; end
                        F3_XOR:  begin opsel = ALU_XOR;  legal = 1'b1; end
                        F3_SLT:  begin opsel = ALU_SLT;  legal = 1'b1; end
                        F3_SLTU: begin opsel = ALU_SLTU; legal = 1'b1; end
                        default: legal = 1'b0;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    opsel = ALU_SUB;
                    legal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                uses_rs1 = 1'b1;
                // Shift immediates (funct3 001/101) fall to default and stay illegal.
                case (funct3)
                    F3_ADD:  begin opsel = ALU_ADDI;  legal = 1'b1; end
                    F3_AND:  begin opsel = ALU_ANDI;  legal = 1'b1; end
                    F3_OR:   begin opsel = ALU_ORI;   legal = 1'b1; end
                    F3_XOR:  begin opsel = ALU_XORI;  legal = 1'b1; end
                    F3_SLT:  begin opsel = ALU_SLTI;  legal = 1'b1; end
                    F3_SLTU: begin opsel = ALU_SLTIU; legal = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                opsel = ALU_LUI;
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                opsel = ALU_AUIPC;
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign writes_rd = legal && (rd != 5'd0);

endmodule

// File: rtl/rv32_decode.sv
// Registered decode stage feeding the integer ALU, with a single-instruction-distance
// RAW interlock that inserts HAZARD_STALL bubbles.
module rv32_decode
    import rv32_pkg::*;
#(
    parameter int HAZARD_STALL = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        flush,
    input  logic        ex_stall,
    output logic        alu_enable,
    output logic [3:0]  alu_opsel,
    output logic [31:0] code_bus,
    output logic [31:0] dec_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic        illegal
);

    localparam logic [1:0] CNT_LOAD = 2'(HAZARD_STALL - 1);

    rv32_alu_op_e dec_opsel;
    logic         dec_legal;
    logic         dec_uses_rs1;
    logic         dec_uses_rs2;
    logic         dec_writes_rd;
    logic [4:0]   dec_rs1;
    logic [4:0]   dec_rs2;
    logic [4:0]   dec_rd;

    logic [1:0]   cnt;
    logic [4:0]   last_rd;
    logic         last_we;
    logic         hit;

    rv32_dec_comb u_dec (
        .instr     (if_instr),
        .opsel     (dec_opsel),
        .legal     (dec_legal),
        .uses_rs1  (dec_uses_rs1),
        .uses_rs2  (dec_uses_rs2),
        .writes_rd (dec_writes_rd),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .rd        (dec_rd)
    );

    // Only the immediately preceding legal writer is tracked; older producers are
    // assumed to be covered by forwarding further down the pipe.
    always_comb begin
        hit = if_valid && dec_legal && last_we && (last_rd != 5'd0) && (cnt == 2'd0)
              && ((dec_uses_rs1 && (last_rd == dec_rs1)) ||
                  (dec_uses_rs2 && (last_rd == dec_rs2)));
        if_ready = rst_n && !ex_stall && !flush && (cnt == 2'd0) && !hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_enable <= 1'b0;
            alu_opsel  <= 4'd0;
            code_bus   <= 32'd0;
            dec_pc     <= 32'd0;
            rs1_addr   <= 5'd0;
            rs2_addr   <= 5'd0;
            rd_addr    <= 5'd0;
            rd_we      <= 1'b0;
            illegal    <= 1'b0;
            cnt        <= 2'd0;
            last_rd    <= 5'd0;
            last_we    <= 1'b0;
        end else if (flush) begin
            alu_enable <= 1'b0;
            rd_we      <= 1'b0;
            illegal    <= 1'b0;
            cnt        <= 2'd0;
            last_we    <= 1'b0;
        end else if (!ex_stall) begin
            if (cnt != 2'd0) begin
                alu_enable <= 1'b0;
                rd_we      <= 1'b0;
                illegal    <= 1'b0;
                cnt        <= cnt - 2'd1;
            end else if (hit) begin
                // The hit cycle is itself the first bubble, so load one less.
                alu_enable <= 1'b0;
                rd_we      <= 1'b0;
                illegal    <= 1'b0;
                cnt        <= CNT_LOAD;
                last_we    <= 1'b0;
            end else if (if_valid) begin
                alu_enable <= dec_legal;
                alu_opsel  <= dec_opsel;
                code_bus   <= if_instr;
                dec_pc     <= if_pc;
                rs1_addr   <= dec_rs1;
                rs2_addr   <= dec_rs2;
                rd_addr    <= dec_rd;
                rd_we      <= dec_writes_rd;
                illegal    <= !dec_legal;
                if (dec_legal) begin
                    last_rd <= dec_rd;
                    last_we <= dec_writes_rd;
                end
            end else begin
                alu_enable <= 1'b0;
                rd_we      <= 1'b0;
                illegal    <= 1'b0;
            end
        end
    end

endmodule
